// File: rtl/parallel_descrambler_pkg.sv
// parallel_descrambler_pkg: scrambler constants and frame FSM state shared by the descrambler files
package parallel_descrambler_pkg;
  localparam int SCR_ORDER   = 7;
  localparam int SCR_TAP_A   = 6;
  localparam int SCR_TAP_B   = 3;
  localparam int SERVICE_LEN = 16;
  typedef enum logic [1:0] {IDLE, SVC, RUN} state_e;
endpackage

// File: rtl/parallel_descrambler_scr_step.sv
// parallel_descrambler_scr_step: one beat of the x^7+x^4+1 descrambler unrolled over DATA_W bits
module parallel_descrambler_scr_step
  import parallel_descrambler_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [SCR_ORDER-1:0] s_i,
  input  logic [DATA_W-1:0]    r_i,
  input  logic [DATA_W-1:0]    seed_mask_i,
  output logic [SCR_ORDER-1:0] s_next_o,
  output logic [DATA_W-1:0]    out_o
);
  logic [SCR_ORDER-1:0] st;
  logic                 sb;
  always_comb begin
    st    = s_i;
    sb    = 1'b0;
    out_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      sb       = seed_mask_i[i] ? r_i[i] : st[SCR_TAP_A] ^ st[SCR_TAP_B];
      out_o[i] = seed_mask_i[i] ? 1'b0 : r_i[i] ^ sb;
      st       = {st[SCR_ORDER-2:0], sb};
    end
    s_next_o = st;
  end
endmodule

// File: rtl/parallel_descrambler.sv
// parallel_descrambler: 802.11a receive descrambler with per-frame seed recovery,
// reserved SERVICE bit checking and a registered valid/ready output stage.
module parallel_descrambler
  import parallel_descrambler_pkg::*;
#(
  parameter int                   DATA_W    = 8,
  parameter bit                   MODE      = 1'b0,
  parameter logic [SCR_ORDER-1:0] INIT_SEED = 7'h7F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    in_data_i,
  input  logic                 in_valid_i,
  input  logic                 in_first_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  output logic [DATA_W-1:0]    out_data_o,
  output logic                 out_valid_o,
  output logic                 out_first_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic [SCR_ORDER-1:0] seed_out_o,
  output logic                 seed_valid_o,
  output logic                 service_err_o
);
  localparam int             CW    = 6;
  localparam logic [CW-1:0]  ORD_N = CW'(SCR_ORDER);
  localparam logic [CW-1:0]  SVC_N = CW'(SERVICE_LEN);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, base_cnt, cnt_sum, idx, sidx;
  logic [SCR_ORDER-1:0] s_q, s_base, s_next, seed_q, seed_d;
  logic [DATA_W-1:0]    seed_mask, chk_mask, desc;
  logic [DATA_W-1:0]    out_data_q;
  logic                 out_valid_q, out_first_q, out_last_q;
  logic                 seed_valid_q, seed_valid_d, err_q, err_d;
  logic                 take;

  assign in_ready_o    = !out_valid_q | out_ready_i;
  assign take          = in_valid_i & in_ready_o & (in_first_i | (state_q != IDLE));
  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;
  assign out_first_o   = out_first_q;
  assign out_last_o    = out_last_q;
  assign seed_out_o    = seed_q;
  assign seed_valid_o  = seed_valid_q;
  assign service_err_o = err_q;

  // Frame bit position of every lane decides seeding and which SERVICE bits are checked.
  always_comb begin
    seed_mask = '0;
    chk_mask  = '0;
    idx       = '0;
    base_cnt  = in_first_i ? '0 : cnt_q;
    s_base    = (MODE && in_first_i) ? INIT_SEED : s_q;
    for (int i = 0; i < DATA_W; i++) begin
      idx          = base_cnt + CW'(i);
      seed_mask[i] = !MODE && (idx < ORD_N);
      chk_mask[i]  = (idx < SVC_N) && (MODE || (idx >= ORD_N));
    end
  end

  parallel_descrambler_scr_step #(.DATA_W(DATA_W)) u_step (
    .s_i        (s_base),
    .r_i        (in_data_i),
    .seed_mask_i(seed_mask),
    .s_next_o   (s_next),
    .out_o      (desc)
  );

  // Sequence bit of each lane is r ^ out, which also covers seeding lanes where out is 0.
  always_comb begin
    sidx         = '0;
    seed_d       = in_first_i ? '0 : seed_q;
    cnt_sum      = base_cnt + CW'(DATA_W);
    cnt_d        = (cnt_sum > SVC_N) ? SVC_N : cnt_sum;
    seed_valid_d = (!in_first_i & seed_valid_q) | ((base_cnt < ORD_N) && (cnt_sum >= ORD_N));
    err_d        = (!in_first_i & err_q) | |(desc & chk_mask);
    state_d      = !take ? state_q : in_last_i ? IDLE : (cnt_d == SVC_N) ? RUN : SVC;
    for (int i = 0; i < DATA_W; i++) begin
      sidx = base_cnt + CW'(i);
      if (sidx < ORD_N) seed_d[sidx[2:0]] = in_data_i[i] ^ desc[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      s_q          <= '0;
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
      err_q        <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        cnt_q        <= cnt_d;
        s_q          <= s_next;
        seed_q       <= seed_d;
        seed_valid_q <= seed_valid_d;
        err_q        <= err_d;
        out_data_q   <= desc;
        out_first_q  <= in_first_i;
        out_last_q   <= in_last_i;
      end
      if (in_ready_o) out_valid_q <= take;
    end
  end
endmodule

// File: tb/tb_parallel_descrambler.sv
// tb_parallel_descrambler: random and directed frames through MODE=0 and MODE=1 instances,
// checked against a bit-level sequence model of the 802.11a scrambler.
module tb_parallel_descrambler;
  localparam int DW    = 8;
  localparam int TXMAX = 512;
  localparam logic [6:0] INIT = 7'h7F;

  typedef struct packed {
    logic [DW-1:0] d0, d1;
    logic          f, l;
    logic [6:0]    s0, s1;
    logic          v0, v1, e0, e1;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready0, in_ready1, ov0, ov1, of0, of1, ol0, ol1, svo0, svo1, se0, se1;
  logic [DW-1:0] od0, od1;
  logic [6:0] so0, so1;

  int vectors = 0, miscompares = 0;
  int rdy_pct = 100, stall_n = 0, nbit = 0;
  bit acc, act = 0;
  bit q0[$], q1[$];
  bit pn[0:TXMAX-1];
  logic [6:0] ms0, ms1;
  bit mv0, mv1, me0, me1;
  logic [DW-1:0] last0 = '0;
  exp_t sb[$];

  always #5 clk = ~clk;

  parallel_descrambler #(.DATA_W(DW), .MODE(1'b0), .INIT_SEED(INIT)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_first_i(in_first), .in_last_i(in_last), .in_ready_o(in_ready0),
    .out_data_o(od0), .out_valid_o(ov0), .out_first_o(of0), .out_last_o(ol0),
    .out_ready_i(out_ready), .seed_out_o(so0), .seed_valid_o(svo0), .service_err_o(se0));

  parallel_descrambler #(.DATA_W(DW), .MODE(1'b1), .INIT_SEED(INIT)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_first_i(in_first), .in_last_i(in_last), .in_ready_o(in_ready1),
    .out_data_o(od1), .out_valid_o(ov1), .out_first_o(of1), .out_last_o(ol1),
    .out_ready_i(out_ready), .seed_out_o(so1), .seed_valid_o(svo1), .service_err_o(se1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scrambler sequence s(0..) starting from a 7-bit state whose bit k is s(-1-k).
  task automatic build(input logic [6:0] sd);
    bit e[$];
    for (int k = 6; k >= 0; k--) e.push_back(sd[k]);
    for (int j = 0; j < TXMAX; j++) e.push_back(e[e.size()-7] ^ e[e.size()-4]);
    for (int j = 0; j < TXMAX; j++) pn[j] = e[j+7];
  endtask

  task automatic model_beat(input logic [DW-1:0] r, input bit f, input bit l);
    exp_t e;
    bit s0, s1;
    if (f) begin
      act = 1; nbit = 0; q0 = {}; q1 = {};
      for (int k = 6; k >= 0; k--) q1.push_back(INIT[k]);
      ms0 = '0; ms1 = '0; mv0 = 0; mv1 = 0; me0 = 0; me1 = 0;
    end
    if (!act) return;
    e = '0;
    for (int i = 0; i < DW; i++) begin
      s0 = (nbit < 7) ? r[i] : (q0[q0.size()-7] ^ q0[q0.size()-4]);
      s1 = q1[q1.size()-7] ^ q1[q1.size()-4];
      q0.push_back(s0);
      q1.push_back(s1);
      e.d0[i] = (nbit < 7) ? 1'b0 : (r[i] ^ s0);
      e.d1[i] = r[i] ^ s1;
      if (nbit < 7) begin ms0[nbit] = s0; ms1[nbit] = s1; end
      if (nbit == 6) begin mv0 = 1; mv1 = 1; end
      if (nbit >= 7 && nbit < 16 && e.d0[i]) me0 = 1;
      if (nbit < 16 && e.d1[i]) me1 = 1;
      nbit++;
    end
    e.f = f; e.l = l; e.s0 = ms0; e.s1 = ms1;
    e.v0 = mv0; e.v1 = mv1; e.e0 = me0; e.e1 = me1;
    sb.push_back(e);
    if (l) act = 0;
  endtask

  task automatic check_cycle();
    exp_t e;
    chk("valid0", ov0, sb.size() != 0);
    chk("valid1", ov1, sb.size() != 0);
    chk("ready0", in_ready0, sb.size() == 0 || out_ready);
    chk("ready1", in_ready1, sb.size() == 0 || out_ready);
    if (sb.size() != 0) begin
      e = sb[0];
      chk("data0", od0, e.d0);    chk("data1", od1, e.d1);
      chk("first0", of0, e.f);    chk("first1", of1, e.f);
      chk("last0", ol0, e.l);     chk("last1", ol1, e.l);
      chk("seed0", so0, e.s0);    chk("seed1", so1, e.s1);
      chk("seedv0", svo0, e.v0);  chk("seedv1", svo1, e.v1);
      chk("err0", se0, e.e0);     chk("err1", se1, e.e1);
      if (out_ready) begin last0 = od0; void'(sb.pop_front()); end
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit f, input bit l);
    @(negedge clk);
    in_valid = v; in_data = d; in_first = f; in_last = l;
    out_ready = (stall_n > 0) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    if (stall_n > 0) stall_n--;
    #1;
    check_cycle();
    acc = v && in_ready0;
    if (acc) model_beat(d, f, l);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit f, input bit l);
    int t = 0;
    do begin step(1, d, f, l); t++; end while (!acc && t < 200);
    chk("accept", acc, 1);
  endtask

  task automatic send_frame(input logic [6:0] sd, input int nb, input bit term, input int flip);
    logic [DW-1:0] d;
    int n;
    build(sd);
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < DW; i++) begin
        n = b * DW + i;
        if (n < 16) d[i] = (n == flip) ^ pn[n];
        else d[i] = 1'($urandom_range(0, 1)) ^ pn[n];
      end
      while ($urandom_range(0, 3) == 0) step(0, DW'($urandom), 0, 0);
      send_beat(d, b == 0, term && b == nb - 1);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) step(0, '0, 0, 0);
    chk("drain", sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_v"}, {ov0, ov1, of0, of1, ol0, ol1}, 0);
    chk({tag, "_d"}, {od0, od1}, 0);
    chk({tag, "_s"}, {so0, so1, svo0, svo1}, 0);
    chk({tag, "_e"}, {se0, se1}, 0);
    chk({tag, "_rdy"}, {in_ready0, in_ready1}, 2'b11);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    send_beat(8'h70, 1, 0); send_beat(8'h4F, 0, 0); send_beat(8'h6C, 0, 1);
    drain();
    chk("ex1_data", last0, 8'hFF);
    chk("ex1_seed", so0, 7'h70);
    chk("ex1_err0", se0, 0);
    chk("ex1_err1", se1, 0);

    send_beat(8'h70, 1, 0); send_beat(8'h4E, 0, 0); send_beat(8'h6C, 0, 1);
    drain();
    chk("ex2_err", se0, 1);
    repeat (4) step(1, DW'($urandom), 0, 0);
    drain();
    chk("ex2_sticky", se0, 1);

    send_beat(8'h70, 1, 0);
    stall_n = 5;
    send_beat(8'h4F, 0, 0); send_beat(8'h6C, 0, 1);
    drain();
    chk("stall_last", last0, 8'hFF);

    send_frame(7'h2A, 1, 0, 7);
    send_frame(7'h55, 4, 1, -1);
    drain();
    chk("abort_err", se0, 0);

    send_frame(7'h01, 2, 1, -1);
    drain();
    chk("m1_seed01_err", se1, 1);
    chk("m0_seed01_err", se0, 0);

    rdy_pct = 60;
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) stall_n = $urandom_range(1, 6);
      send_frame(7'($urandom), $urandom_range(1, 6), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 1) ? -1 : int'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step(1, DW'($urandom), 0, 0);
    end
    drain();

    rdy_pct = 100;
    send_frame(7'h33, 3, 0, -1);
    #2 rst_n = 1'b0;
    sb = {}; act = 0;
    #1 check_zero("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    send_beat(8'h70, 1, 0); send_beat(8'h4F, 0, 0); send_beat(8'h6C, 0, 1);
    drain();
    chk("post_rst_data", last0, 8'hFF);
    chk("post_rst_seed", so0, 7'h70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
